wb_axi_burst_bridge: RTL and testbench
======================================

# wb_axi_burst_bridge

Wishbone B4 slave to AXI4 master bridge that sits between a Wishbone master and the MIG DDR AXI slave port. It converts Wishbone incrementing bursts into AXI INCR read bursts. It steers narrow Wishbone data onto a wider AXI data bus and reports AXI error responses per beat. Writes remain single-beat AXI transactions.

## Interface
Parameters:
- WB_DATA_WIDTH, 32: Wishbone data width; WBB = WB_DATA_WIDTH/8 bytes.
- AXI_DATA_WIDTH, 64: AXI data width; RATIO = AXI_DATA_WIDTH/WB_DATA_WIDTH, power of 2, ≥1.
- ADDR_WIDTH, 28: byte address width, both buses.
- AXI_ID_WIDTH, 2 / AXI_ID, 0: constant ID on AW and AR.
- READ_BURST_LEN, 8: maximum AXI read beats per prefetch, power of 2, 1..256.

Ports:
- clk  in  1  sole clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone cycle/strobe/write.
- wb_adr_i  in  ADDR_WIDTH  byte address, WBB-aligned.
- wb_dat_i  in  WB_DATA_WIDTH / wb_sel_i  in  WBB  write data/byte selects.
- wb_cti_i  in  3 / wb_bte_i  in  2  cycle type / burst type.
- wb_ack_o, wb_err_o, wb_rty_o  out  1  termination; wb_rty_o tied 0.
- wb_dat_o  out  WB_DATA_WIDTH  read data.
- AXI4 AW/W/B/AR/R master channels: m_axi_aw{id,addr,len,size,burst,cache,prot,qos,valid,ready}, m_axi_w{data,strb,last,valid,ready}, m_axi_b{id,resp,valid,ready}, m_axi_ar{...same as AW}, m_axi_r{id,data,resp,last,valid,ready}. Widths are per AXI4 with ADDR_WIDTH, AXI_DATA_WIDTH and AXI_ID_WIDTH.

## Operation
- Constants: burst=INCR, cache=0000, prot=010, qos=0. awsize = arsize = log2(WBB) (narrow transfers). awlen=0, wlast=1.
- Lane: lane(a) = (a/WBB) mod RATIO.
- Write data: wdata = wb_dat_i replicated RATIO times. wstrb = wb_sel_i << (lane·WBB), all other bits 0.
- Read data: wb_dat_o = rdata slice [lane(exp_adr)].
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RD_DRAIN.
- IDLE + cyc&stb&we → WR. Latch address, data, sel.
- WR: awvalid and wvalid assert together. Each channel drops independently after its own handshake. When both are done → WR_RESP.
- WR_RESP: bready=1. On bvalid, ack (bresp[1]=0) or err (bresp[1]=1) for one cycle → IDLE.
- IDLE + cyc&stb&!we → RD_ADDR. Latch exp_adr = wb_adr_i. Compute arlen:
  - Burst read (cti=010 and bte=00): beats = min(READ_BURST_LEN, (4096 − adr[11:0])/WBB), arlen = beats−1.
  - Any other cti/bte: arlen=0.
- RD_ADDR: arvalid=1 until arready → RD_DATA.
- RD_DATA:
  - match = cyc & stb & !we & (adr == exp_adr). rready = match.
  - On rvalid&rready: ack if rresp[1]=0, else err. exp_adr += WBB.
  - rlast beat → IDLE.
  - Non-last beat with err, or with cti=111 → RD_DRAIN.
  - !match while beats remain → RD_DRAIN.
- RD_DRAIN: rready=1, no Wishbone termination, beats discarded. rlast → IDLE.
- A Wishbone burst longer than one AXI burst continues as a new AR from IDLE.
- Write during a pending read prefetch: served only after the drain completes.
- Termination: exactly one of ack/err per Wishbone beat. Never asserted outside a live cyc&stb.

## Timing
- Reset (rst_n=0, async): state=IDLE. All m_axi_*valid=0, bready=0, rready=0. wb_ack_o=wb_err_o=0. wb_dat_o=0. awdone/wdone cleared.
- The Wishbone request is registered. AR/AW/W valid rise the cycle after stb is sampled in IDLE.
- Read first-beat latency: 1 cycle (IDLE) + AR handshake + slave latency.
- Read streaming: subsequent beats ack combinationally from rvalid, 1 beat/cycle.
- Write latency: 1 cycle + max(AW, W handshake) + B latency. Ack is combinational from bvalid.
- Valid outputs never drop before their ready (AXI rule), including when the Wishbone cyc drops mid-handshake. The transaction completes and its ack is suppressed if cyc=0.
- rst_n asserted mid-burst: immediate return to IDLE. The AXI slave must be reset concurrently.

## Test plan
- Single write at adr 0x004, sel=0xF, dat=0xDEADBEEF, RATIO=2:
  - AW: awaddr=0x004, awlen=0.
  - W: wdata=0xDEADBEEF_DEADBEEF, wstrb=0xF0.
  - One ack after bvalid.
- 8-beat cti=010 read from 0x100, slave returns rdata = beat index in both lanes:
  - One AR: arlen=7, arsize=2.
  - 8 acks with wb_dat_o 0..7, back-to-back cycles.
- Burst read from 0xFF8: arlen=1 (4 KB cap). Third beat issues a second AR at 0x1000.
- Master ends burst with cti=111 on beat 3 of 8: 3 acks, 5 beats drained, state returns to IDLE, then a following write completes normally.
- rresp=SLVERR on beat 2: err on beat 2, remaining beats drained. Separately, bresp=DECERR on a write → err.
- rst_n pulsed low during RD_DATA: all valids and ack 0 in the same cycle; the next read proceeds from IDLE.

Source files
------------

// File: rtl/wb_axi_burst_bridge.sv
// wb_axi_burst_bridge: Wishbone B4 slave to AXI4 master; incrementing WB reads become AXI INCR
// prefetch bursts, writes stay single narrow beats steered onto the wide AXI data lanes.
module wb_axi_burst_bridge #(
   parameter int WB_DATA_WIDTH  = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int ADDR_WIDTH     = 28,
   parameter int AXI_ID_WIDTH   = 2,
   parameter int AXI_ID         = 0,
   parameter int READ_BURST_LEN = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wb_cyc_i,
   input  logic                        wb_stb_i,
   input  logic                        wb_we_i,
   input  logic [ADDR_WIDTH-1:0]       wb_adr_i,
   input  logic [WB_DATA_WIDTH-1:0]    wb_dat_i,
   input  logic [WB_DATA_WIDTH/8-1:0]  wb_sel_i,
   input  logic [2:0]                  wb_cti_i,
   input  logic [1:0]                  wb_bte_i,
   output logic                        wb_ack_o,
   output logic                        wb_err_o,
   output logic                        wb_rty_o,
   output logic [WB_DATA_WIDTH-1:0]    wb_dat_o,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_awid_o,
   output logic [ADDR_WIDTH-1:0]       m_axi_awaddr_o,
   output logic [7:0]                  m_axi_awlen_o,
   output logic [2:0]                  m_axi_awsize_o,
   output logic [1:0]                  m_axi_awburst_o,
   output logic [3:0]                  m_axi_awcache_o,
   output logic [2:0]                  m_axi_awprot_o,
   output logic [3:0]                  m_axi_awqos_o,
   output logic                        m_axi_awvalid_o,
   input  logic                        m_axi_awready_i,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata_o,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb_o,
   output logic                        m_axi_wlast_o,
   output logic                        m_axi_wvalid_o,
   input  logic                        m_axi_wready_i,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid_i,
   input  logic [1:0]                  m_axi_bresp_i,
   input  logic                        m_axi_bvalid_i,
   output logic                        m_axi_bready_o,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_arid_o,
   output logic [ADDR_WIDTH-1:0]       m_axi_araddr_o,
   output logic [7:0]                  m_axi_arlen_o,
   output logic [2:0]                  m_axi_arsize_o,
   output logic [1:0]                  m_axi_arburst_o,
   output logic [3:0]                  m_axi_arcache_o,
   output logic [2:0]                  m_axi_arprot_o,
   output logic [3:0]                  m_axi_arqos_o,
   output logic                        m_axi_arvalid_o,
   input  logic                        m_axi_arready_i,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid_i,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata_i,
   input  logic [1:0]                  m_axi_rresp_i,
   input  logic                        m_axi_rlast_i,
   input  logic                        m_axi_rvalid_i,
   output logic                        m_axi_rready_o
);
   localparam int WBB   = WB_DATA_WIDTH / 8;
   localparam int SBB   = AXI_DATA_WIDTH / 8;
   localparam int RATIO = AXI_DATA_WIDTH / WB_DATA_WIDTH;
   localparam int SZ    = $clog2(WBB);
   localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

   typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RD_DRAIN} state_e;

   state_e                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    adr_q, adr_d;
   logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
   logic [WBB-1:0]           sel_q, sel_d;
   logic [7:0]               arlen_q, arlen_d;
   logic                     awdone_q, awdone_d, wdone_q, wdone_d;
   logic [LW-1:0]            lane;
   logic [12:0]              rem, cap, beats;
   logic                     live, match, unused_ok;

   assign live  = wb_cyc_i & wb_stb_i;
   assign match = live & ~wb_we_i & (wb_adr_i == adr_q);
   assign lane  = adr_q[SZ +: LW] & LW'(RATIO - 1);
   // prefetch never crosses a 4 KB page, as AXI forbids
   assign rem   = 13'd4096 - {1'b0, wb_adr_i[11:0]};
   assign cap   = rem >> SZ;
   assign beats = (wb_cti_i == 3'b010 && wb_bte_i == 2'b00)
                ? ((cap > 13'(READ_BURST_LEN)) ? 13'(READ_BURST_LEN) : cap) : 13'd1;

   assign wb_rty_o        = 1'b0;
   assign m_axi_awid_o    = AXI_ID_WIDTH'(AXI_ID);
   assign m_axi_awaddr_o  = adr_q;
   assign m_axi_awlen_o   = 8'd0;
   assign m_axi_awsize_o  = 3'(SZ);
   assign m_axi_awburst_o = 2'b01;
   assign m_axi_awcache_o = 4'b0000;
   assign m_axi_awprot_o  = 3'b010;
   assign m_axi_awqos_o   = 4'd0;
   assign m_axi_wdata_o   = {RATIO{dat_q}};
   assign m_axi_wstrb_o   = SBB'(sel_q) << (lane * WBB);
   assign m_axi_wlast_o   = 1'b1;
   assign m_axi_arid_o    = AXI_ID_WIDTH'(AXI_ID);
   assign m_axi_araddr_o  = adr_q;
   assign m_axi_arlen_o   = arlen_q;
   assign m_axi_arsize_o  = 3'(SZ);
   assign m_axi_arburst_o = 2'b01;
   assign m_axi_arcache_o = 4'b0000;
   assign m_axi_arprot_o  = 3'b010;
   assign m_axi_arqos_o   = 4'd0;
   assign unused_ok       = ^{m_axi_bid_i, m_axi_rid_i, m_axi_bresp_i[0], m_axi_rresp_i[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         arlen_q  <= '0;
         awdone_q <= 1'b0;
         wdone_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         sel_q    <= sel_d;
         arlen_q  <= arlen_d;
         awdone_q <= awdone_d;
         wdone_q  <= wdone_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      adr_d           = adr_q;
      dat_d           = dat_q;
      sel_d           = sel_q;
      arlen_d         = arlen_q;
      awdone_d        = awdone_q;
      wdone_d         = wdone_q;
      m_axi_awvalid_o = 1'b0;
      m_axi_wvalid_o  = 1'b0;
      m_axi_bready_o  = 1'b0;
      m_axi_arvalid_o = 1'b0;
      m_axi_rready_o  = 1'b0;
      wb_ack_o        = 1'b0;
      wb_err_o        = 1'b0;
      wb_dat_o        = '0;
      case (state_q)
         IDLE: if (live) begin
            adr_d    = wb_adr_i;
            dat_d    = wb_dat_i;
            sel_d    = wb_sel_i;
            arlen_d  = 8'(beats - 13'd1);
            awdone_d = 1'b0;
            wdone_d  = 1'b0;
            state_d  = wb_we_i ? WR : RD_ADDR;
         end
         WR: begin
            m_axi_awvalid_o = ~awdone_q;
            m_axi_wvalid_o  = ~wdone_q;
            awdone_d        = awdone_q | m_axi_awready_i;
            wdone_d         = wdone_q | m_axi_wready_i;
            state_d         = (awdone_d & wdone_d) ? WR_RESP : WR;
         end
         WR_RESP: begin
            m_axi_bready_o = 1'b1;
            wb_ack_o       = m_axi_bvalid_i & live & ~m_axi_bresp_i[1];
            wb_err_o       = m_axi_bvalid_i & live & m_axi_bresp_i[1];
            state_d        = m_axi_bvalid_i ? IDLE : WR_RESP;
         end
         RD_ADDR: begin
            m_axi_arvalid_o = 1'b1;
            state_d         = m_axi_arready_i ? RD_DATA : RD_ADDR;
         end
         RD_DATA: begin
            m_axi_rready_o = match;
            if (m_axi_rvalid_i & match) begin
               wb_ack_o = ~m_axi_rresp_i[1];
               wb_err_o = m_axi_rresp_i[1];
               wb_dat_o = WB_DATA_WIDTH'(m_axi_rdata_i >> (lane * WB_DATA_WIDTH));
               adr_d    = adr_q + ADDR_WIDTH'(WBB);
               state_d  = m_axi_rlast_i ? IDLE
                        : ((m_axi_rresp_i[1] | (wb_cti_i == 3'b111)) ? RD_DRAIN : RD_DATA);
            end else if (!match) begin
               state_d = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            m_axi_rready_o = 1'b1;
            state_d        = (m_axi_rvalid_i & m_axi_rlast_i) ? IDLE : RD_DRAIN;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_wb_axi_burst_bridge.sv
// tb_wb_axi_burst_bridge: directed Wishbone traffic against a behavioural AXI slave; expected
// AW/W/AR beats and Wishbone terminations are queued and checked by a separate monitor.
module tb_wb_axi_burst_bridge;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_cyc, wb_stb, wb_we;
   logic [27:0] wb_adr;
   logic [31:0] wb_dat;
   logic [3:0]  wb_sel;
   logic [2:0]  wb_cti;
   logic [1:0]  wb_bte;
   logic        wb_ack, wb_err, wb_rty;
   logic [31:0] wb_rdat;
   logic [1:0]  awid, arid;
   logic [27:0] awaddr, araddr;
   logic [7:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, arsize, awprot, arprot;
   logic [1:0]  awburst, arburst;
   logic [3:0]  awcache, arcache, awqos, arqos;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [63:0] wdata, rdata;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   wb_axi_burst_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
      .wb_dat_i(wb_dat), .wb_sel_i(wb_sel), .wb_cti_i(wb_cti), .wb_bte_i(wb_bte),
      .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_rty_o(wb_rty), .wb_dat_o(wb_rdat),
      .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize),
      .m_axi_awburst_o(awburst), .m_axi_awcache_o(awcache), .m_axi_awprot_o(awprot),
      .m_axi_awqos_o(awqos), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
      .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
      .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
      .m_axi_bid_i(2'd0), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
      .m_axi_arid_o(arid), .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize),
      .m_axi_arburst_o(arburst), .m_axi_arcache_o(arcache), .m_axi_arprot_o(arprot),
      .m_axi_arqos_o(arqos), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
      .m_axi_rid_i(2'd0), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
      .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
   );

   typedef struct {logic [27:0] addr; logic [7:0] len;} ax_t;
   typedef struct {logic [63:0] data; logic [7:0] strb;} w_t;
   typedef struct {logic err; logic rd; logic [31:0] dat;} t_t;

   ax_t exp_aw[$], exp_ar[$];
   w_t  exp_w[$];
   t_t  exp_t[$];
   int  term_cyc[$];
   ax_t ma, mr;
   w_t  mw;
   t_t  mt;
   int  errors = 0, checks = 0, cyc_n = 0;
   int  w_delay = 0, err_beat = -1, rbeats = 0, rb0;
   logic [1:0] bresp_cfg = 2'b00;
   bit  lanes_distinct = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_aw(input logic [27:0] a);
      ax_t e;
      e.addr = a; e.len = 8'd0; exp_aw.push_back(e);
   endtask
   task automatic push_ar(input logic [27:0] a, input logic [7:0] l);
      ax_t e;
      e.addr = a; e.len = l; exp_ar.push_back(e);
   endtask
   task automatic push_w(input logic [63:0] d, input logic [7:0] s);
      w_t e;
      e.data = d; e.strb = s; exp_w.push_back(e);
   endtask
   task automatic push_t(input logic e, input logic r, input logic [31:0] d);
      t_t t;
      t.err = e; t.rd = r; t.dat = d; exp_t.push_back(t);
   endtask

   always @(posedge clk) cyc_n++;

   // scoreboard monitor
   always @(negedge clk) begin
      if (awvalid & awready) begin
         if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
         else begin
            ma = exp_aw.pop_front();
            chk("aw_addr", awaddr, ma.addr);
            chk("aw_len", awlen, ma.len);
            chk("aw_attr", {awid, awsize, awburst, awcache, awprot, awqos}, {2'd0, 3'd2, 2'b01, 4'd0, 3'b010, 4'd0});
         end
      end
      if (wvalid & wready) begin
         if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
         else begin
            mw = exp_w.pop_front();
            chk("w_data", wdata, mw.data);
            chk("w_strb", wstrb, mw.strb);
            chk("w_last", wlast, 1);
         end
      end
      if (arvalid & arready) begin
         if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
         else begin
            mr = exp_ar.pop_front();
            chk("ar_addr", araddr, mr.addr);
            chk("ar_len", arlen, mr.len);
            chk("ar_attr", {arid, arsize, arburst, arcache, arprot, arqos}, {2'd0, 3'd2, 2'b01, 4'd0, 3'b010, 4'd0});
         end
      end
      if (wb_ack | wb_err) begin
         term_cyc.push_back(cyc_n);
         chk("term_live", wb_cyc & wb_stb, 1);
         chk("term_onehot", wb_ack & wb_err, 0);
         if (exp_t.size() == 0) chk("term_unexpected", 1, 0);
         else begin
            mt = exp_t.pop_front();
            chk("term_err", wb_err, mt.err);
            if (mt.rd && !mt.err) chk("rd_data", wb_rdat, mt.dat);
         end
      end
   end

   // AXI write slave: AW always ready, W ready after w_delay cycles of wvalid
   initial begin
      bit aw_hs, w_hs, b_hs, wv, aw_seen, w_seen;
      int wcnt;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
      aw_seen = 0; w_seen = 0; wcnt = 0;
      forever begin
         @(negedge clk);
         aw_hs = awvalid & awready; w_hs = wvalid & wready; b_hs = bvalid & bready; wv = wvalid;
         @(posedge clk); #1;
         if (!rst_n) begin
            aw_seen = 0; w_seen = 0; bvalid = 1'b0; wcnt = 0; wready = (w_delay == 0);
         end else begin
            if (aw_hs) aw_seen = 1;
            if (w_hs) w_seen = 1;
            if (b_hs) bvalid = 1'b0;
            if (aw_seen && w_seen && !bvalid) begin
               bvalid = 1'b1; bresp = bresp_cfg; aw_seen = 0; w_seen = 0;
            end
            wcnt   = w_hs ? 0 : (wv ? wcnt + 1 : wcnt);
            wready = (wcnt >= w_delay);
         end
      end
   end

   // AXI read slave: beat i returns i in both lanes, or distinct per-lane patterns
   initial begin
      bit ar_hs, r_hs, active;
      logic [7:0] arl;
      int lens[$];
      int beat, cur_len;
      arready = 1'b1; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
      active = 0; beat = 0; cur_len = 0;
      forever begin
         @(negedge clk);
         ar_hs = arvalid & arready; arl = arlen; r_hs = rvalid & rready;
         @(posedge clk); #1;
         if (!rst_n) begin
            lens.delete(); active = 0; rvalid = 1'b0; rlast = 1'b0;
         end else begin
            if (ar_hs) lens.push_back(int'(arl));
            if (r_hs) begin
               rbeats++;
               if (beat == cur_len) active = 0;
               else beat++;
            end
            if (!active && lens.size() > 0) begin
               cur_len = lens.pop_front(); beat = 0; active = 1;
            end
            rvalid = active;
            rlast  = active && (beat == cur_len);
            rdata  = lanes_distinct ? {32'(32'hA000_0000 + beat), 32'(32'h5000_0000 + beat)}
                                    : {32'(beat), 32'(beat)};
            rresp  = (active && beat == err_beat) ? 2'b10 : 2'b00;
         end
      end
   end

   task automatic wait_term(output bit e);
      int t;
      t = 0; e = 0;
      forever begin
         @(negedge clk);
         if (wb_ack | wb_err) break;
         t++;
         if (t >= 200) begin
            chk("term_timeout", 1, 0);
            break;
         end
      end
      e = wb_err;
      @(posedge clk); #1;
   endtask

   task automatic wb_write(input logic [27:0] a, input logic [31:0] d, input logic [3:0] s);
      bit e;
      wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = a; wb_dat = d; wb_sel = s; wb_cti = 3'b000; wb_bte = 2'b00;
      wait_term(e);
      wb_cyc = 0; wb_stb = 0; wb_we = 0;
   endtask

   task automatic wb_read(input logic [27:0] a, input int n, input bit end111, input bit keep);
      bit e;
      wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_bte = 2'b00;
      for (int k = 0; k < n; k++) begin
         wb_adr = a + 28'(4 * k);
         wb_cti = (end111 && k == n - 1) ? 3'b111 : 3'b010;
         wait_term(e);
         if (e) break;
      end
      if (keep) begin
         wb_adr = a + 28'(4 * n); wb_cti = 3'b010;
      end else begin
         wb_cyc = 0; wb_stb = 0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_cti = '0; wb_bte = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valids", {awvalid, wvalid, arvalid}, 0);
      chk("rst_readies", {bready, rready}, 0);
      chk("rst_term", {wb_ack, wb_err, wb_rty}, 0);
      chk("rst_dat", wb_rdat, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // single write, lane 1, delayed W handshake
      w_delay = 2;
      push_aw(28'h004); push_w(64'hDEADBEEF_DEADBEEF, 8'hF0); push_t(0, 0, 0);
      wb_write(28'h004, 32'hDEADBEEF, 4'hF);
      w_delay = 0;

      // 8-beat burst read, back-to-back acks
      push_ar(28'h100, 8'd7);
      for (int i = 0; i < 8; i++) push_t(0, 1, 32'(i));
      term_cyc.delete(); rb0 = rbeats;
      wb_read(28'h100, 8, 1, 0);
      repeat (2) @(posedge clk); #1;
      chk("b2b_count", 64'(term_cyc.size()), 8);
      if (term_cyc.size() == 8) chk("b2b_span", 64'(term_cyc[7] - term_cyc[0]), 7);
      chk("rd8_beats", 64'(rbeats - rb0), 8);

      // 4 KB cap then continuation AR
      push_ar(28'hFF8, 8'd1); push_ar(28'h1000, 8'd7);
      push_t(0, 1, 0); push_t(0, 1, 1); push_t(0, 1, 0); push_t(0, 1, 1);
      rb0 = rbeats;
      wb_read(28'hFF8, 4, 1, 0);
      repeat (12) @(posedge clk); #1;
      chk("cap_beats", 64'(rbeats - rb0), 10);

      // early end on beat 3, drain, then a write
      push_ar(28'h200, 8'd7);
      push_t(0, 1, 0); push_t(0, 1, 1); push_t(0, 1, 2);
      rb0 = rbeats;
      wb_read(28'h200, 3, 1, 0);
      push_aw(28'h208); push_w(64'h12345678_12345678, 8'h03); push_t(0, 0, 0);
      wb_write(28'h208, 32'h12345678, 4'h3);
      repeat (2) @(posedge clk); #1;
      chk("drain_beats", 64'(rbeats - rb0), 8);

      // SLVERR on beat 2, then DECERR on a write
      lanes_distinct = 1; err_beat = 1;
      push_ar(28'h304, 8'd7);
      push_t(0, 1, 32'hA000_0000); push_t(1, 1, 0);
      rb0 = rbeats;
      wb_read(28'h304, 4, 1, 0);
      bresp_cfg = 2'b11;
      push_aw(28'h40C); push_w(64'hCAFEF00D_CAFEF00D, 8'hC0); push_t(1, 0, 0);
      wb_write(28'h40C, 32'hCAFEF00D, 4'hC);
      bresp_cfg = 2'b00; err_beat = -1;
      repeat (2) @(posedge clk); #1;
      chk("slverr_beats", 64'(rbeats - rb0), 8);

      // reset pulse during RD_DATA
      lanes_distinct = 0;
      push_ar(28'h500, 8'd7);
      push_t(0, 1, 0); push_t(0, 1, 1);
      wb_read(28'h500, 2, 0, 1);
      #1;
      chk("pre_rst_ack", wb_ack, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valids", {awvalid, wvalid, arvalid}, 0);
      chk("mid_rst_readies", {bready, rready}, 0);
      chk("mid_rst_term", {wb_ack, wb_err}, 0);
      wb_cyc = 0; wb_stb = 0;
      repeat (2) @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      lanes_distinct = 1;
      push_ar(28'h508, 8'd0); push_t(0, 1, 32'h5000_0000);
      wb_read(28'h508, 1, 1, 0);

      repeat (5) @(posedge clk); #1;
      chk("aw_left", 64'(exp_aw.size()), 0);
      chk("w_left", 64'(exp_w.size()), 0);
      chk("ar_left", 64'(exp_ar.size()), 0);
      chk("term_left", 64'(exp_t.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
